// File: rtl/dff_response_checker_if.sv
// Bundle of stimulus taps and result signals between a lab3 storage-element
// experiment and its response checker. The master side (bench or board glue)
// drives Start and the D/Q taps; the slave side (the checker) drives results.
interface dff_response_checker_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             d;
    logic             q;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] first_err;

    modport master (
        output start, d, q,
        input  busy, done, pass, err_count, first_err
    );

    modport slave (
        input  start, d, q,
        output busy, done, pass, err_count, first_err
    );
endinterface

// File: rtl/dff_response_checker.sv
// Observer for the lab3 flip-flop/latch experiments. It rebuilds the response
// of an ideal posedge D flip-flop (D delayed by LATENCY clocks) and compares
// it with the DUT's Q over WINDOW cycles, reporting a mismatch count, the
// index of the first mismatch and a pass flag.
// Optional feature macro: DFF_CHECK_STOP_ON_ERR_EN -- when defined, the first
// mismatch ends the run early and goes straight to the report cycle.
module dff_response_checker #(
    parameter int LATENCY = 1,
    parameter int WINDOW  = 16,
    parameter int CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    dff_response_checker_if.slave bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FILL   = 2'd1;
    localparam logic [1:0] CHECK  = 2'd2;
    localparam logic [1:0] REPORT = 2'd3;

    localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CHECK_LAST = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] ALL_ONES   = {CNT_W{1'b1}};

    logic [1:0]         state;
    logic [CNT_W-1:0]   cycle_cnt;
    logic [CNT_W-1:0]   err_count;
    logic [CNT_W-1:0]   first_err;
    logic               pass;
    logic [LATENCY-1:0] pipe;
    logic               expected;
    logic               mismatch;

    assign expected = pipe[LATENCY-1];
    assign mismatch = (bus.q != expected);

    // Expected-value pipeline: shifts D in on every edge regardless of state,
    // so the last stage always holds D from LATENCY cycles earlier.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe <= '0;
        end else begin
            pipe[0] <= bus.d;
            for (int i = 1; i < LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Run sequencer: FILL lets the pipeline load D from this run, CHECK
    // accumulates mismatches with a saturating count, REPORT latches Pass.
    // The all-ones First_err value doubles as the "no mismatch yet" flag,
    // since a real compare index never reaches all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cycle_cnt <= '0;
            err_count <= '0;
            first_err <= ALL_ONES;
            pass      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state     <= FILL;
                        cycle_cnt <= '0;
                        err_count <= '0;
                        first_err <= ALL_ONES;
                    end
                end
                FILL: begin
                    if (cycle_cnt == FILL_LAST) begin
                        state     <= CHECK;
                        cycle_cnt <= '0;
                    end else begin
                        cycle_cnt <= cycle_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    cycle_cnt <= cycle_cnt + 1'b1;
                    if (cycle_cnt == CHECK_LAST) begin
                        state <= REPORT;
                    end
                    if (mismatch) begin
                        if (err_count != ALL_ONES) begin
                            err_count <= err_count + 1'b1;
                        end
                        if (first_err == ALL_ONES) begin
                            first_err <= cycle_cnt;
                        end
`ifdef DFF_CHECK_STOP_ON_ERR_EN
                        state <= REPORT;
`else
`endif
                    end
                end
                REPORT: begin
                    pass  <= (err_count == '0);
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == REPORT);
    assign bus.pass      = pass;
    assign bus.err_count = err_count;
    assign bus.first_err = first_err;

endmodule

// File: tb/tb_dff_response_checker.sv
// Self-checking bench for dff_response_checker. Three checker instances cover
// the default configuration, LATENCY=2/WINDOW=8 and CNT_W=3/WINDOW=7. Each run
// pre-generates its D/Q stimulus, derives the expected verdict and timing from
// the flip-flop rule by plain arithmetic, then plays the stimulus cycle by cycle.
module tb_dff_response_checker;

`ifdef DFF_CHECK_STOP_ON_ERR_EN
    localparam bit STOP_ON_ERR = 1'b1;
`else
    localparam bit STOP_ON_ERR = 1'b0;
`endif

    logic clk;
    logic rst;

    int nChecks = 0;
    int nFails  = 0;
    int curSel  = 0;
    bit prevPass [3];

    dff_response_checker_if #(.CNT_W(8)) if0 ();
    dff_response_checker_if #(.CNT_W(8)) if1 ();
    dff_response_checker_if #(.CNT_W(3)) if2 ();

    dff_response_checker #(.LATENCY(1), .WINDOW(16), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .bus(if0)
    );
    dff_response_checker #(.LATENCY(2), .WINDOW(8), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .bus(if1)
    );
    dff_response_checker #(.LATENCY(1), .WINDOW(7), .CNT_W(3)) dut2 (
        .clk(clk), .rst(rst), .bus(if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs of the currently selected instance, zero-extended to a common width.
    logic       obsBusy, obsDone, obsPass;
    logic [7:0] obsErr, obsFirst;

    always_comb begin
        obsBusy  = if0.busy;
        obsDone  = if0.done;
        obsPass  = if0.pass;
        obsErr   = if0.err_count;
        obsFirst = if0.first_err;
        case (curSel)
            1: begin
                obsBusy  = if1.busy;
                obsDone  = if1.done;
                obsPass  = if1.pass;
                obsErr   = if1.err_count;
                obsFirst = if1.first_err;
            end
            2: begin
                obsBusy  = if2.busy;
                obsDone  = if2.done;
                obsPass  = if2.pass;
                obsErr   = {5'b0, if2.err_count};
                obsFirst = {5'b0, if2.first_err};
            end
            default: ;
        endcase
    end

    function automatic int latOf(input int sel);
        return (sel == 1) ? 2 : 1;
    endfunction

    function automatic int winOf(input int sel);
        return (sel == 0) ? 16 : ((sel == 1) ? 8 : 7);
    endfunction

    function automatic int maxOf(input int sel);
        return (sel == 2) ? 7 : 255;
    endfunction

    task automatic checkOutput(input string tag, input int obs, input int exp);
        nChecks++;
        assert (obs === exp)
        else begin
            nFails++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic driveInputs(input int sel, input bit s, input bit dv, input bit qv);
        if0.d = dv;
        if1.d = dv;
        if2.d = dv;
        if0.start = (sel == 0) ? s : 1'b0;
        if1.start = (sel == 1) ? s : 1'b0;
        if2.start = (sel == 2) ? s : 1'b0;
        if0.q = (sel == 0) ? qv : 1'b0;
        if1.q = (sel == 1) ? qv : 1'b0;
        if2.q = (sel == 2) ? qv : 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            driveInputs(curSel, 1'b0, 1'b0, 1'b0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkResetState(input string tag);
        for (int s = 0; s < 3; s++) begin
            curSel = s;
            #1;
            checkOutput({tag, "_busy"},  int'(obsBusy),  0);
            checkOutput({tag, "_done"},  int'(obsDone),  0);
            checkOutput({tag, "_pass"},  int'(obsPass),  0);
            checkOutput({tag, "_err"},   int'(obsErr),   0);
            checkOutput({tag, "_first"}, int'(obsFirst), maxOf(s));
        end
    endtask

    // mode 0: Q is D delayed LATENCY; 1: Q stuck at 0 with D alternating;
    // 2: as mode 0 with Q flipped at compare index flipIdx; 3: Q is inverted delayed D.
    // restartAt: offset of an extra Start pulse (-1 none, -2 the report cycle).
    // abortAt: offset at which reset is asserted mid-run (-1 none).
    task automatic applyStimulus(input string tag, input int sel, input int mode,
                                 input int flipIdx, input int restartAt, input int abortAt);
        int lat, win, maxc, errN, firstI, rep, expErr, expFirst, reAt;
        bit stopped, expPass, phase, src;
        bit dArr [40];
        bit qArr [40];

        lat    = latOf(sel);
        win    = winOf(sel);
        maxc   = maxOf(sel);
        curSel = sel;
        phase  = 1'($urandom_range(0, 1));

        for (int j = 0; j < 40; j++) begin
            dArr[j] = (mode == 1) ? (phase ^ j[0]) : 1'($urandom_range(0, 1));
        end
        for (int j = 0; j < 40; j++) begin
            src = (j >= lat) ? dArr[j-lat] : 1'b0;
            case (mode)
                1:       qArr[j] = 1'b0;
                2:       qArr[j] = (j == lat + 1 + flipIdx) ? ~src : src;
                3:       qArr[j] = ~src;
                default: qArr[j] = src;
            endcase
        end

        // Compare i happens at offset lat+1+i and expects D sampled at offset 1+i.
        errN   = 0;
        firstI = -1;
        for (int i = 0; i < win; i++) begin
            if (qArr[lat+1+i] != dArr[1+i]) begin
                errN++;
                if (firstI < 0) firstI = i;
            end
        end
        stopped  = STOP_ON_ERR && (errN > 0);
        rep      = lat + 1 + (stopped ? firstI : win - 1);
        expErr   = stopped ? 1 : ((errN > maxc) ? maxc : errN);
        expFirst = (firstI < 0) ? maxc : firstI;
        expPass  = (errN == 0);
        reAt     = (restartAt == -2) ? rep : restartAt;

        for (int j = 0; j <= rep + 2; j++) begin
            if (j == abortAt) begin
                driveInputs(sel, 1'b0, dArr[j], qArr[j]);
                rst = 1'b1;
                #1;
                checkOutput({tag, "_abort_busy"},  int'(obsBusy),  0);
                checkOutput({tag, "_abort_done"},  int'(obsDone),  0);
                checkOutput({tag, "_abort_pass"},  int'(obsPass),  0);
                checkOutput({tag, "_abort_err"},   int'(obsErr),   0);
                checkOutput({tag, "_abort_first"}, int'(obsFirst), maxc);
                #2;
                rst = 1'b0;
                for (int k = 0; k < 3; k++) prevPass[k] = 1'b0;
                for (int k = 0; k < rep + 4; k++) begin
                    driveInputs(sel, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
                    @(posedge clk);
                    #1;
                    checkOutput({tag, "_post_abort_done"}, int'(obsDone), 0);
                    checkOutput({tag, "_post_abort_busy"}, int'(obsBusy), 0);
                end
                return;
            end
            driveInputs(sel, (j == 0) || (j == reAt), dArr[j], qArr[j]);
            @(posedge clk);
            #1;
            checkOutput({tag, "_busy"}, int'(obsBusy), (j <= rep) ? 1 : 0);
            checkOutput({tag, "_done"}, int'(obsDone), (j == rep) ? 1 : 0);
            checkOutput({tag, "_pass"}, int'(obsPass),
                        (j > rep) ? int'(expPass) : int'(prevPass[sel]));
            if (j >= rep) begin
                checkOutput({tag, "_err"},   int'(obsErr),   expErr);
                checkOutput({tag, "_first"}, int'(obsFirst), expFirst);
            end
        end
        prevPass[sel] = expPass;
        $display("[TB] %s done: errors=%0d first=%0d pass=%0d", tag, expErr, expFirst, expPass);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) prevPass[k] = 1'b0;
        rst = 1'b1;
        driveInputs(0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkResetState("reset");
        rst = 1'b0;
        idleCycles(2);

        applyStimulus("dff_ok",      0, 0, 0, -1, -1);
        idleCycles(2);
        applyStimulus("stuck0",      0, 1, 0, -1, -1);
        idleCycles(2);
        applyStimulus("lat2_flip5",  1, 2, 5, -1, -1);
        idleCycles(2);
        applyStimulus("abort",       0, 1, 0, -1, 5);
        checkResetState("after_abort");
        idleCycles(1);
        applyStimulus("fresh",       0, 0, 0, -1, -1);
        idleCycles(2);
        applyStimulus("cnt3_inv",    2, 3, 0, -1, -1);
        idleCycles(2);
        applyStimulus("restart_mid", 0, 0, 0, 8, -1);
        idleCycles(2);
        applyStimulus("restart_rep", 1, 0, 0, -2, -1);
        idleCycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
